// File: rtl/uart_rx_pkt_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------------+
// | uart_rx_pkt_parser: frames UART bytes into HEADER/LEN/payload/CHK packets       |
// | Revision 1.0                                                                    |
// +--------------------------------------------------------------------------------+
module uart_rx_pkt_parser #(
  parameter logic [7:0] HEADER       = 8'hAA,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 104170
) (
  input  logic                           i_Clock,
  input  logic                           i_Rst_n,
  input  logic                           i_Rx_DV,
  input  logic [7:0]                     i_Rx_Byte,
  input  logic [$clog2(MAX_LEN)-1:0]     i_Rd_Addr,
  output logic [7:0]                     o_Rd_Data,
  output logic                           o_Pkt_DV,
  output logic [$clog2(MAX_LEN+1)-1:0]   o_Pkt_Len,
  output logic                           o_Pkt_Err,
  output logic [1:0]                     o_Err_Code,
  output logic                           o_Busy,
  output logic [7:0]                     o_Pkt_Cnt
);

  localparam int              AW        = $clog2(MAX_LEN);
  localparam int              LW        = $clog2(MAX_LEN + 1);
  localparam int              TW        = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LEN     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CHK     = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    len, len_nxt;
  logic [7:0]    chk_acc, chk_nxt;
  logic [AW-1:0] idx, idx_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic          pkt_good, pkt_bad, buf_we;
  logic [1:0]    err_code;
  logic [7:0]    buffer [MAX_LEN];

  assign o_Busy = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    chk_nxt   = chk_acc;
    idx_nxt   = idx;
    tmo_nxt   = tmo_cnt;
    pkt_good  = 1'b0;
    pkt_bad   = 1'b0;
    err_code  = 2'd0;
    buf_we    = 1'b0;

    if (state != S_IDLE) tmo_nxt = tmo_cnt + TW'(1);
    if (i_Rx_DV)         tmo_nxt = '0;

    case (state)
      S_IDLE: begin
        if (i_Rx_DV && i_Rx_Byte == HEADER) state_nxt = S_LEN;
      end
      S_LEN: begin
        if (i_Rx_DV) begin
          len_nxt = i_Rx_Byte;
          chk_nxt = i_Rx_Byte;
          idx_nxt = '0;
          if (i_Rx_Byte > MAX_LEN_B) begin
            pkt_bad   = 1'b1;
            err_code  = 2'd2;
            state_nxt = S_IDLE;
          end else if (i_Rx_Byte == 8'd0) begin
            state_nxt = S_CHK;
          end else begin
            state_nxt = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (i_Rx_DV) begin
          buf_we  = i_Rst_n;
          chk_nxt = chk_acc ^ i_Rx_Byte;
          idx_nxt = idx + AW'(1);
          if (8'(idx) == len - 8'd1) state_nxt = S_CHK;
        end
      end
      S_CHK: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == chk_acc) begin
            pkt_good = 1'b1;
          end else begin
            pkt_bad  = 1'b1;
            err_code = 2'd1;
          end
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // A strobe on the last allowed clock keeps the packet alive.
    if (state != S_IDLE && !i_Rx_DV && tmo_cnt == TMO_LAST) begin
      pkt_bad   = 1'b1;
      err_code  = 2'd3;
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state      <= S_IDLE;
      len        <= '0;
      chk_acc    <= '0;
      idx        <= '0;
      tmo_cnt    <= '0;
      o_Pkt_DV   <= 1'b0;
      o_Pkt_Err  <= 1'b0;
      o_Err_Code <= '0;
      o_Pkt_Len  <= '0;
      o_Pkt_Cnt  <= '0;
      o_Rd_Data  <= '0;
    end else begin
      state     <= state_nxt;
      len       <= len_nxt;
      chk_acc   <= chk_nxt;
      idx       <= idx_nxt;
      tmo_cnt   <= tmo_nxt;
      o_Pkt_DV  <= pkt_good;
      o_Pkt_Err <= pkt_bad;
      if (pkt_bad) o_Err_Code <= err_code;
      if (pkt_good) begin
        o_Pkt_Len <= len[LW-1:0];
        o_Pkt_Cnt <= o_Pkt_Cnt + 8'd1;
      end
      o_Rd_Data <= buffer[i_Rd_Addr];
    end
  end

  // Payload storage carries no reset; its contents are only meaningful after o_Pkt_DV.
  always_ff @(posedge i_Clock) begin
    if (buf_we) buffer[idx] <= i_Rx_Byte;
  end

endmodule
`default_nettype wire
